// File: rtl/fp4_dot_mac_if.sv
// Operand-beat, flush and result handshake bundle for fp4_dot_mac.
// The master side is the operand streamer / result consumer; the slave side is the MAC.
interface fp4_dot_mac_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 16
);
    logic                   i_in_valid;
    logic                   o_in_ready;
    logic [LANES-1:0]       i_lane_en;
    logic [4*LANES-1:0]     i_a;
    logic [4*LANES-1:0]     i_b;
    logic                   i_flush;
    logic                   o_fp4_valid;
    logic                   i_out_ready;
    logic [3:0]             o_fp4;
    logic                   o_zero;
    logic                   o_acc_sat;
    logic [ACC_W-1:0]       o_acc;

    modport master (
        output i_in_valid, i_lane_en, i_a, i_b, i_flush, i_out_ready,
        input  o_in_ready, o_fp4_valid, o_fp4, o_zero, o_acc_sat, o_acc
    );

    modport slave (
        input  i_in_valid, i_lane_en, i_a, i_b, i_flush, i_out_ready,
        output o_in_ready, o_fp4_valid, o_fp4, o_zero, o_acc_sat, o_acc
    );
endinterface

// File: rtl/fp4_dot_mac.sv
// LANES-wide FP4 dot-product MAC: exact products summed into a clamped fixed-point
// accumulator (LSB 1/16); a flush returns one rounded, saturated FP4 value over valid/ready.
module fp4_dot_mac #(
    parameter int LANES          = 4,
    parameter int ACC_W          = 16,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    fp4_dot_mac_if.slave bus
);
    localparam int PROD_W = 11;
    localparam int TREE_W = 16;
    localparam int SUM_W  = ((ACC_W > TREE_W) ? ACC_W : TREE_W) + 1;
    localparam logic signed [SUM_W-1:0] POS_LIM = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] NEG_LIM = -POS_LIM;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Exact product in 1/16 units: (2+ma)(2+mb) << (ea+eb), signed by sa^sb.
    function automatic logic signed [PROD_W-1:0] fp4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0]        sig;
        logic [2:0]        sh;
        logic [PROD_W-1:0] mag;
        sig = {2'b00, 1'b1, a[0]} * {2'b00, 1'b1, b[0]};
        sh  = {1'b0, a[2:1]} + {1'b0, b[2:1]};
        mag = {{(PROD_W-4){1'b0}}, sig} << sh;
        fp4_mul = (a[3] ^ b[3]) ? ({PROD_W{1'b0}} - mag) : mag;
    endfunction

    // Returns {zero, s, e[1:0], m}. Thresholds are midpoints between FP4 magnitudes;
    // ties fall to the m=0 neighbour, and 0.25 falls to zero.
    function automatic logic [4:0] fp4_round(input logic signed [ACC_W-1:0] acc);
        logic [ACC_W-1:0] mag;
        logic [2:0]       em;
        mag = acc[ACC_W-1] ? ({ACC_W{1'b0}} - acc) : acc;
        if      (mag <= ACC_W'(32'd10)) em = 3'b000;
        else if (mag <  ACC_W'(32'd14)) em = 3'b001;
        else if (mag <= ACC_W'(32'd20)) em = 3'b010;
        else if (mag <  ACC_W'(32'd28)) em = 3'b011;
        else if (mag <= ACC_W'(32'd40)) em = 3'b100;
        else if (mag <  ACC_W'(32'd56)) em = 3'b101;
        else if (mag <= ACC_W'(32'd80)) em = 3'b110;
        else                            em = 3'b111;
        if (mag <= ACC_W'(32'd4)) fp4_round = 5'b10000;
        else                      fp4_round = {1'b0, acc[ACC_W-1], em};
    endfunction

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      in_ready_q;
    logic                      valid_q;
    logic [3:0]                fp4_q;
    logic                      zero_q;
    logic                      sat_q, sat_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_out_q;
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic signed [PROD_W-1:0]  prod_d [LANES];
    logic signed [TREE_W-1:0]  tree_q, tree_d;
    logic signed [SUM_W-1:0]   sum_s;
    logic                      beat_s;
    logic                      flush_s;
    logic                      capture_s;
    logic [4:0]                conv_s;

    assign beat_s  = bus.i_in_valid & in_ready_q;
    assign flush_s = bus.i_flush & in_ready_q;
    assign conv_s  = fp4_round(acc_q);

    // Stage P: per-lane products; idle cycles and disabled lanes feed zeros down the pipe.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            if (beat_s && bus.i_lane_en[k]) prod_d[k] = fp4_mul(bus.i_a[4*k +: 4], bus.i_b[4*k +: 4]);
            else                            prod_d[k] = {PROD_W{1'b0}};
        end
    end

    // Stage P register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= {PROD_W{1'b0}};
        end else if (i_clear) begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= {PROD_W{1'b0}};
        end else begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
        end
    end

    // Stage T: signed sum of all lane products.
    always_comb begin
        tree_d = {TREE_W{1'b0}};
        for (int k = 0; k < LANES; k++) tree_d = tree_d + TREE_W'(prod_q[k]);
    end

    // Stage T register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     tree_q <= {TREE_W{1'b0}};
        else if (i_clear) tree_q <= {TREE_W{1'b0}};
        else              tree_q <= tree_d;
    end

    // Stage A: symmetric clamp, sticky saturation, optional clear when the result is captured.
    always_comb begin
        sum_s = SUM_W'(acc_q) + SUM_W'(tree_q);
        acc_d = acc_q;
        sat_d = sat_q;
        if (capture_s && CLEAR_ON_FLUSH) begin
            acc_d = {ACC_W{1'b0}};
            sat_d = 1'b0;
        end else if (sum_s > POS_LIM) begin
            acc_d = POS_LIM[ACC_W-1:0];
            sat_d = 1'b1;
        end else if (sum_s < NEG_LIM) begin
            acc_d = NEG_LIM[ACC_W-1:0];
            sat_d = 1'b1;
        end else begin
            acc_d = sum_s[ACC_W-1:0];
        end
    end

    // Accumulator, saturation flag and the one-cycle-delayed debug copy of the accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q     <= {ACC_W{1'b0}};
            sat_q     <= 1'b0;
            acc_out_q <= {ACC_W{1'b0}};
        end else if (i_clear) begin
            acc_q     <= {ACC_W{1'b0}};
            sat_q     <= 1'b0;
            acc_out_q <= {ACC_W{1'b0}};
        end else begin
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            acc_out_q <= acc_q;
        end
    end

    // Control: ACCUM -> DRAIN on flush, capture after the pipe has emptied, OUT until consumed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (flush_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 2'd3) begin
                    capture_s = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_OUT: begin
                if (bus.i_out_ready) state_d = ST_ACCUM;
                else                 state_d = ST_OUT;
            end
            default: begin
                state_d = ST_ACCUM;
                cnt_d   = 2'd0;
            end
        endcase
        if (i_clear) begin
            state_d   = ST_ACCUM;
            cnt_d     = 2'd0;
            capture_s = 1'b0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ACCUM;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered handshake and result; ready stays low while in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            fp4_q      <= 4'b0000;
            zero_q     <= 1'b0;
        end else begin
            in_ready_q <= (state_d == ST_ACCUM);
            valid_q    <= (state_d == ST_OUT);
            if (i_clear) begin
                fp4_q  <= 4'b0000;
                zero_q <= 1'b0;
            end else if (capture_s) begin
                fp4_q  <= conv_s[3:0];
                zero_q <= conv_s[4];
            end else begin
                fp4_q  <= fp4_q;
                zero_q <= zero_q;
            end
        end
    end

    assign bus.o_in_ready  = in_ready_q;
    assign bus.o_fp4_valid = valid_q;
    assign bus.o_fp4       = fp4_q;
    assign bus.o_zero      = zero_q;
    assign bus.o_acc_sat   = sat_q;
    assign bus.o_acc       = acc_out_q;
endmodule

// File: tb/tb_fp4_dot_mac.sv
// Directed bench for fp4_dot_mac: three instances share one stimulus stream
// (ACC_W=16 clear-on-flush, ACC_W=12 clear-on-flush, ACC_W=16 keep-accumulating).
module tb_fp4_dot_mac;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [3:0]  lane_en;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        flush;
    logic        out_ready;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fp4_dot_mac_if #(.LANES(4), .ACC_W(16)) if0 ();
    fp4_dot_mac_if #(.LANES(4), .ACC_W(12)) if1 ();
    fp4_dot_mac_if #(.LANES(4), .ACC_W(16)) if2 ();

    assign if0.i_in_valid = in_valid;  assign if1.i_in_valid = in_valid;  assign if2.i_in_valid = in_valid;
    assign if0.i_lane_en  = lane_en;   assign if1.i_lane_en  = lane_en;   assign if2.i_lane_en  = lane_en;
    assign if0.i_a        = a_in;      assign if1.i_a        = a_in;      assign if2.i_a        = a_in;
    assign if0.i_b        = b_in;      assign if1.i_b        = b_in;      assign if2.i_b        = b_in;
    assign if0.i_flush    = flush;     assign if1.i_flush    = flush;     assign if2.i_flush    = flush;
    assign if0.i_out_ready = out_ready; assign if1.i_out_ready = out_ready; assign if2.i_out_ready = out_ready;

    fp4_dot_mac #(.LANES(4), .ACC_W(16), .CLEAR_ON_FLUSH(1'b1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .bus(if0));
    fp4_dot_mac #(.LANES(4), .ACC_W(12), .CLEAR_ON_FLUSH(1'b1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .bus(if1));
    fp4_dot_mac #(.LANES(4), .ACC_W(16), .CLEAR_ON_FLUSH(1'b0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .bus(if2));

    typedef struct packed {
        logic [3:0]         en;
        logic [15:0]        a;
        logic [15:0]        b;
        logic signed [15:0] acc;
        logic [3:0]         fp4;
        logic               zero;
    } vec_t;

    // Single-beat rounding vectors; lanes left disabled carry 6.0 operands to expose masking faults.
    localparam vec_t VECS [11] = '{
        '{4'b0001, 16'h7770, 16'h7770,  16'sd4,  4'b0000, 1'b1},
        '{4'b0001, 16'h7770, 16'h7771,  16'sd6,  4'b0000, 1'b0},
        '{4'b0011, 16'h7700, 16'h7710,  16'sd10, 4'b0000, 1'b0},
        '{4'b0011, 16'h7701, 16'h7701,  16'sd13, 4'b0001, 1'b0},
        '{4'b0011, 16'h7700, 16'h7712,  16'sd14, 4'b0010, 1'b0},
        '{4'b0011, 16'h7723, 16'h7722,  16'sd40, 4'b0100, 1'b0},
        '{4'b0111, 16'h7023, 16'h7023,  16'sd56, 4'b0110, 1'b0},
        '{4'b0011, 16'h7724, 16'h7724,  16'sd80, 4'b0110, 1'b0},
        '{4'b0111, 16'h7024, 16'h7024,  16'sd84, 4'b0111, 1'b0},
        '{4'b0011, 16'h77BB, 16'h7732, -16'sd60, 4'b1110, 1'b0},
        '{4'b1111, 16'h2222, 16'h2222,  16'sd64, 4'b0110, 1'b0}
    };

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [3:0] en, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        lane_en  = en;
        a_in     = a;
        b_in     = b;
    endtask

    // Raises flush (alongside any beat already set up) and waits for the result.
    task automatic run_flush();
        int n;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("drain_ready", 32'(if0.o_in_ready), 32'd0);
        n = 0;
        while (!if0.o_fp4_valid && n < 12) begin
            step();
            n++;
        end
        chk("result_latency", n, 32'd4);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; lane_en = 4'b0000;
        a_in = 16'h0000; b_in = 16'h0000; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(if0.o_in_ready), 32'd0);
        chk("rst_valid", 32'(if0.o_fp4_valid), 32'd0);
        chk("rst_fp4", 32'(if0.o_fp4), 32'd0);
        chk("rst_zero", 32'(if0.o_zero), 32'd0);
        chk("rst_sat", 32'(if0.o_acc_sat), 32'd0);
        chk("rst_acc", 32'(if0.o_acc), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_release_ready", 32'(if0.o_in_ready), 32'd1);

        // 1.5*1.5 + 1.5*1.0 = 3.75 (60), lanes 2-3 masked; o_acc shows it after edge k+3
        set_beat(4'b0011, 16'h7733, 16'h7723);
        step();
        in_valid = 1'b0;
        step(); step();
        chk("t1_acc_k2", 32'($signed(if0.o_acc)), 32'd0);
        step();
        chk("t1_acc_k3", 32'($signed(if0.o_acc)), 32'd60);
        run_flush();
        chk("t1_fp4", 32'(if0.o_fp4), 32'b0110);
        chk("t1_zero", 32'(if0.o_zero), 32'd0);
        step();
        chk("t1_valid_drop", 32'(if0.o_fp4_valid), 32'd0);
        chk("t1_ready_back", 32'(if0.o_in_ready), 32'd1);
        chk("t1_acc_cleared", 32'($signed(if0.o_acc)), 32'd0);

        // two beats of 4 x (1.0*1.0) = 8.0 saturates to 6.0 without clamping the accumulator
        set_beat(4'b1111, 16'h2222, 16'h2222);
        step(); step();
        in_valid = 1'b0;
        run_flush();
        chk("t2_fp4", 32'(if0.o_fp4), 32'b0111);
        chk("t2_acc", 32'($signed(if0.o_acc)), 32'd128);
        chk("t2_sat", 32'(if0.o_acc_sat), 32'd0);
        step();

        // -1.5 + 1.0 = -0.5
        set_beat(4'b0001, 16'h777B, 16'h7772);
        step();
        set_beat(4'b0001, 16'h7772, 16'h7772);
        step();
        in_valid = 1'b0;
        run_flush();
        chk("t3_fp4", 32'(if0.o_fp4), 32'b1000);
        chk("t3_acc", 32'($signed(if0.o_acc)), -32'sd8);
        step();
        // 2.25 - 2.25 = 0, beat in the same cycle as the flush
        set_beat(4'b0011, 16'h77B3, 16'h7733);
        run_flush();
        chk("t3_zero_fp4", 32'(if0.o_fp4), 32'd0);
        chk("t3_zero_flag", 32'(if0.o_zero), 32'd1);
        step();

        for (int i = 0; i < 11; i++) begin
            set_beat(VECS[i].en, VECS[i].a, VECS[i].b);
            run_flush();
            chk($sformatf("vec%0d_fp4", i), 32'(if0.o_fp4), 32'(VECS[i].fp4));
            chk($sformatf("vec%0d_zero", i), 32'(if0.o_zero), 32'(VECS[i].zero));
            chk($sformatf("vec%0d_acc", i), 32'($signed(if0.o_acc)), 32'($signed(VECS[i].acc)));
            chk($sformatf("vec%0d_fp4_w12", i), 32'(if1.o_fp4), 32'(VECS[i].fp4));
            step();
            chk($sformatf("vec%0d_done", i), 32'(if0.o_fp4_valid), 32'd0);
        end

        // 4 x (6*6) = 2304 per beat: ACC_W=12 clamps at 2047, ACC_W=16 does not
        set_beat(4'b1111, 16'h7777, 16'h7777);
        step(); step();
        in_valid = 1'b0;
        step(); step();
        chk("clamp_sat_w12", 32'(if1.o_acc_sat), 32'd1);
        chk("clamp_sat_w16", 32'(if0.o_acc_sat), 32'd0);
        run_flush();
        chk("clamp_acc_w12", 32'($signed(if1.o_acc)), 32'd2047);
        chk("clamp_fp4_w12", 32'(if1.o_fp4), 32'b0111);
        chk("clamp_acc_w16", 32'($signed(if0.o_acc)), 32'd4608);
        chk("clamp_sat_cleared", 32'(if1.o_acc_sat), 32'd0);
        step();
        set_beat(4'b1111, 16'hFFFF, 16'h7777);
        run_flush();
        chk("nclamp_acc_w12", 32'($signed(if1.o_acc)), -32'sd2047);
        chk("nclamp_fp4_w12", 32'(if1.o_fp4), 32'b1111);
        chk("nclamp_acc_w16", 32'($signed(if0.o_acc)), -32'sd2304);
        step();

        // back-pressure: result held, offered beat refused until the result is taken
        out_ready = 1'b0;
        set_beat(4'b0001, 16'h7773, 16'h7773);
        run_flush();
        set_beat(4'b0001, 16'h7772, 16'h7772);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_fp4", 32'(if0.o_fp4), 32'b0100);
            chk("bp_valid", 32'(if0.o_fp4_valid), 32'd1);
            chk("bp_ready", 32'(if0.o_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_valid_drop", 32'(if0.o_fp4_valid), 32'd0);
        chk("bp_ready_back", 32'(if0.o_in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("bp_one_beat", 32'($signed(if0.o_acc)), 32'd16);
        run_flush();
        chk("bp_next_fp4", 32'(if0.o_fp4), 32'b0010);
        step();

        // keep-accumulating instance returns the same value on a second flush
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("keep_clear_acc", 32'($signed(if2.o_acc)), 32'd0);
        set_beat(4'b0001, 16'h7773, 16'h7773);
        run_flush();
        chk("keep_fp4_1", 32'(if2.o_fp4), 32'b0100);
        step();
        run_flush();
        chk("keep_fp4_2", 32'(if2.o_fp4), 32'b0100);
        chk("keep_acc_2", 32'($signed(if2.o_acc)), 32'd36);
        chk("cof_zero_2", 32'(if0.o_zero), 32'd1);
        step();

        // clear while draining: no result, accumulator empty
        set_beat(4'b0001, 16'h7773, 16'h7773);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_drain_ready", 32'(if0.o_in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if0.o_fp4_valid) seen++;
        end
        chk("clr_drain_no_result", seen, 32'd0);
        chk("clr_drain_acc", 32'($signed(if0.o_acc)), 32'd0);

        // clear in the same cycle as a beat and flush discards both
        set_beat(4'b0001, 16'h7773, 16'h7773);
        flush = 1'b1; clear = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0; clear = 1'b0;
        chk("clr_beat_ready", 32'(if0.o_in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if0.o_fp4_valid) seen++;
        end
        chk("clr_beat_no_result", seen, 32'd0);
        chk("clr_beat_acc", 32'($signed(if0.o_acc)), 32'd0);

        // asynchronous reset mid-drain
        set_beat(4'b0001, 16'h7773, 16'h7773);
        step(); step();
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(if0.o_in_ready), 32'd0);
        chk("arst_acc", 32'($signed(if0.o_acc)), 32'd0);
        chk("arst_valid", 32'(if0.o_fp4_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_ready_back", 32'(if0.o_in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if0.o_fp4_valid) seen++;
        end
        chk("arst_no_result", seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
